bitreg_scan_display: RTL and testbench

BITREG_SCAN_DISPLAY -- requirements
Module: bitreg_scan_display

---
 rtl/bitreg_scan_display.sv | 141 ++++++++++++++
 tb/tb_bitreg_scan_display.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bitreg_scan_display.sv
// bitreg_scan_display
//   Bit-addressable register with single-bit write/toggle commands and a
//   multiplexed, active-low seven-segment hex display of its contents.
//
//   Optional feature: define BITREG_LZ_BLANK_EN to blank leading-zero
//   digits (digit 0 is always shown).
//
// Parameters
//   WIDTH        register width, multiple of 4 in 8..32
//   NDIG         number of display digits (WIDTH/4, do not override)
//   REFRESH_DIV  clk cycles per digit scan slot (>= 2)
//
// Ports
//   clk        clock, rising edge
//   reset      asynchronous active-low reset
//   bit_index  target bit position
//   bit_value  value written when write=1
//   valid_in   command strobe, accepted on its rising edge only
//   write      1: write bit_value, 0: toggle target bit
//   q          register contents
//   upd        one-cycle pulse while q shows a newly changed value
//   segment    digit enables, active-low one-hot
//   led        segment cathodes a..g (MSB..LSB), active-low

module bitreg_scan_display #(
    parameter int unsigned WIDTH       = 16,
    parameter int unsigned NDIG        = WIDTH / 4,
    parameter int unsigned REFRESH_DIV = 125000
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [$clog2(WIDTH)-1:0] bit_index,
    input  logic                     bit_value,
    input  logic                     valid_in,
    input  logic                     write,
    output logic [WIDTH-1:0]         q,
    output logic                     upd,
    output logic [NDIG-1:0]          segment,
    output logic [6:0]               led
);

    localparam int unsigned CntW = $clog2(REFRESH_DIV);
    localparam int unsigned DigW = $clog2(NDIG);

    logic [WIDTH-1:0] q_q, q_d;
    logic             upd_q;
    logic             valid_q;
    // Cleared by reset; set once valid_in has been seen low, so a strobe
    // already held high across reset release is never taken as a new edge.
    logic             armed_q;
    logic             accept;

    logic [CntW-1:0]  cnt_q, cnt_d;
    logic             cnt_wrap;
    logic [DigW-1:0]  dig_q, dig_d;
    logic [NDIG-1:0]  seg_q, seg_d;
    logic [6:0]       led_q, led_d;
    logic [3:0]       nibble;

    function automatic logic [6:0] hex_glyph(input logic [3:0] n);
        logic [6:0] g;
        g = 7'b1111111;
        case (n)
            4'h0: g = 7'b0000001;
            4'h1: g = 7'b1001111;
            4'h2: g = 7'b0010010;
            4'h3: g = 7'b0000110;
            4'h4: g = 7'b1001100;
            4'h5: g = 7'b0100100;
            4'h6: g = 7'b0100000;
            4'h7: g = 7'b0001111;
            4'h8: g = 7'b0000000;
            4'h9: g = 7'b0000100;
            4'hA: g = 7'b0001000;
            4'hB: g = 7'b1100000;
            4'hC: g = 7'b0110001;
            4'hD: g = 7'b1000010;
            4'hE: g = 7'b0110000;
            4'hF: g = 7'b0111000;
            default: g = 7'b1111111;
        endcase
        return g;
    endfunction

    // Command path
    always_comb begin
        accept = valid_in & ~valid_q & armed_q;
        q_d    = q_q;
        // Out-of-range indices (non-power-of-2 WIDTH) are accepted but ignored.
        if (accept && (32'(bit_index) < WIDTH)) begin
            q_d[bit_index] = write ? bit_value : ~q_q[bit_index];
        end
    end

    // Scan path. Display registers are loaded from next-state values so
    // segment/led always match the current digit pointer and q together.
    always_comb begin
        cnt_wrap = (cnt_q == CntW'(REFRESH_DIV - 1));
        cnt_d    = cnt_wrap ? '0 : cnt_q + CntW'(1);
        dig_d    = dig_q;
        if (cnt_wrap) begin
            dig_d = (dig_q == DigW'(NDIG - 1)) ? '0 : dig_q + DigW'(1);
        end
        nibble = q_d[4*int'(dig_d) +: 4];
        seg_d  = ~(NDIG'(1) << dig_d);
        led_d  = hex_glyph(nibble);
`ifdef BITREG_LZ_BLANK_EN
        if ((dig_d != '0) && ((q_d >> (4 * int'(dig_d))) == '0)) begin
            led_d = 7'b1111111;
        end
`endif
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            q_q     <= '0;
            upd_q   <= 1'b0;
            valid_q <= 1'b0;
            armed_q <= 1'b0;
            cnt_q   <= '0;
            dig_q   <= '0;
            seg_q   <= ~NDIG'(1);
            led_q   <= 7'b0000001;
        end else begin
            q_q     <= q_d;
            upd_q   <= (q_d != q_q);
            valid_q <= valid_in;
            armed_q <= armed_q | ~valid_in;
            cnt_q   <= cnt_d;
            dig_q   <= dig_d;
            seg_q   <= seg_d;
            led_q   <= led_d;
        end
    end

    assign q       = q_q;
    assign upd     = upd_q;
    assign segment = seg_q;
    assign led     = led_q;

endmodule

// File: tb/tb_bitreg_scan_display.sv
// Directed self-checking bench for bitreg_scan_display (WIDTH=16, REFRESH_DIV=4).

module tb_bitreg_scan_display;

    localparam int unsigned W   = 16;
    localparam int unsigned DIV = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  bit_index = '0;
    logic        bit_value = 1'b0;
    logic        valid_in = 1'b0;
    logic        write = 1'b0;
    logic [15:0] q;
    logic        upd;
    logic [3:0]  segment;
    logic [6:0]  led;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    bitreg_scan_display #(
        .WIDTH      (W),
        .REFRESH_DIV(DIV)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .bit_index(bit_index),
        .bit_value(bit_value),
        .valid_in (valid_in),
        .write    (write),
        .q        (q),
        .upd      (upd),
        .segment  (segment),
        .led      (led)
    );

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic logic [6:0] ref_glyph(input logic [3:0] n);
        case (n)
            4'h0: return 7'b0000001;
            4'h1: return 7'b1001111;
            4'h2: return 7'b0010010;
            4'h3: return 7'b0000110;
            4'h4: return 7'b1001100;
            4'h5: return 7'b0100100;
            4'h6: return 7'b0100000;
            4'h7: return 7'b0001111;
            4'h8: return 7'b0000000;
            4'h9: return 7'b0000100;
            4'hA: return 7'b0001000;
            4'hB: return 7'b1100000;
            4'hC: return 7'b0110001;
            4'hD: return 7'b1000010;
            4'hE: return 7'b0110000;
            default: return 7'b0111000;
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Raise valid_in with the given command; returns #1 after the accepting edge.
    task automatic send(input int idx, input logic val, input logic wr);
        @(posedge clk);
        #1;
        bit_index = 4'(idx);
        bit_value = val;
        write     = wr;
        valid_in  = 1'b1;
        tick();
    endtask

    task automatic load_value(input logic [15:0] v);
        for (int i = 0; i < 16; i++) begin
            send(i, v[i], 1'b1);
            valid_in = 1'b0;
        end
        tick();
    endtask

    // Advance to the first cycle of a digit-0 slot; flags a failure on timeout.
    task automatic sync_digit0(output logic ok);
        logic [3:0] prev;
        int n;
        n = 0;
        do begin
            prev = segment;
            tick();
            n++;
        end while (!(segment == 4'b1110 && prev != 4'b1110) && n < 64);
        ok = (n < 64);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL scan_sync: got timeout after %0d cycles, want digit-0 slot start", n);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        #1 reset = 1'b0;
        #1;
        checks++;
        if (q !== 16'h0000) begin
            errors++; $display("FAIL reset_q_async: got %h want 0000", q);
        end
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (q !== 16'h0000) begin errors++; $display("FAIL reset_q: got %h want 0000", q); end
        checks++;
        if (segment !== 4'b1110) begin
            errors++; $display("FAIL reset_segment: got %b want 1110", segment);
        end
        checks++;
        if (led !== 7'b0000001) begin
            errors++; $display("FAIL reset_led: got %b want 0000001", led);
        end
        checks++;
        if (upd !== 1'b0) begin errors++; $display("FAIL reset_upd: got %b want 0", upd); end
        @(negedge clk);
        reset = 1'b1;
        tick();
    endtask

    task automatic test_write();
        send(5, 1'b1, 1'b1);
        checks++;
        if (q !== 16'h0020) begin errors++; $display("FAIL write_q: got %h want 0020", q); end
        checks++;
        if (upd !== 1'b1) begin errors++; $display("FAIL write_upd: got %b want 1", upd); end
        tick();
        checks++;
        if (upd !== 1'b0) begin errors++; $display("FAIL write_upd_pulse: got %b want 0", upd); end
        valid_in = 1'b0;
        send(5, 1'b1, 1'b1);
        checks++;
        if (q !== 16'h0020) begin errors++; $display("FAIL rewrite_q: got %h want 0020", q); end
        checks++;
        if (upd !== 1'b0) begin errors++; $display("FAIL rewrite_upd: got %b want 0", upd); end
        valid_in = 1'b0;
        tick();
    endtask

    task automatic test_toggle_hold();
        int upd_cnt;
        int q_bad;
        upd_cnt = 0;
        q_bad   = 0;
        send(5, 1'b0, 1'b0);
        for (int i = 0; i < 50; i++) begin
            if (upd === 1'b1) upd_cnt++;
            if (q !== 16'h0000) q_bad++;
            tick();
        end
        checks++;
        if (q_bad != 0) begin
            errors++; $display("FAIL toggle_hold_q: got %0d bad cycles want 0", q_bad);
        end
        checks++;
        if (upd_cnt != 1) begin
            errors++; $display("FAIL toggle_hold_upd: got %0d pulses want 1", upd_cnt);
        end
        valid_in = 1'b0;
        tick();
    endtask

    task automatic test_patterns();
        int          idx [6]  = '{15, 0, 15, 0, 9, 9};
        logic        val [6]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        logic        wr  [6]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        logic [15:0] expq [6] = '{16'h8000, 16'h8001, 16'h0001, 16'h0000, 16'h0200, 16'h0000};
        for (int i = 0; i < 6; i++) begin
            send(idx[i], val[i], wr[i]);
            checks++;
            if (q !== expq[i]) begin
                errors++; $display("FAIL pattern%0d_q: got %h want %h", i, q, expq[i]);
            end
            checks++;
            if (upd !== 1'b1) begin
                errors++; $display("FAIL pattern%0d_upd: got %b want 1", i, upd);
            end
            valid_in = 1'b0;
        end
        tick();
    endtask

    task automatic test_scan();
        logic        ok;
        logic [15:0] v;
        logic [3:0]  es;
        logic [6:0]  el;
        v = 16'hA5C3;
        load_value(v);
        checks++;
        if (q !== v) begin errors++; $display("FAIL scan_load: got %h want %h", q, v); end
        sync_digit0(ok);
        if (ok) begin
            for (int i = 0; i < 16; i++) begin
                es = ~(4'b0001 << (i / 4));
                el = ref_glyph(v[4*(i/4) +: 4]);
                checks++;
                if (segment !== es) begin
                    errors++; $display("FAIL scan_seg%0d: got %b want %b", i, segment, es);
                end
                checks++;
                if (led !== el) begin
                    errors++; $display("FAIL scan_led%0d: got %b want %b", i, led, el);
                end
                tick();
            end
            checks++;
            if (segment !== 4'b1110) begin
                errors++; $display("FAIL scan_wrap: got %b want 1110", segment);
            end
        end
    endtask

    task automatic test_lz();
        logic       ok;
        logic [6:0] el;
        load_value(16'h0007);
        checks++;
        if (q !== 16'h0007) begin errors++; $display("FAIL lz_load: got %h want 0007", q); end
        sync_digit0(ok);
        if (ok) begin
            for (int i = 0; i < 16; i++) begin
                if (i < 4) el = 7'b0001111;
`ifdef BITREG_LZ_BLANK_EN
                else el = 7'b1111111;
`else
                else el = 7'b0000001;
`endif
                checks++;
                if (led !== el) begin
                    errors++; $display("FAIL lz_led%0d: got %b want %b", i, led, el);
                end
                tick();
            end
        end
    endtask

    task automatic test_reset_mid();
        int n;
        int q_bad;
        n = 0;
        while (segment !== 4'b1011 && n < 64) begin
            tick();
            n++;
        end
        checks++;
        if (n >= 64) begin errors++; $display("FAIL mid_sync: got timeout want digit 2"); end
        bit_index = 4'd4;
        bit_value = 1'b1;
        write     = 1'b1;
        valid_in  = 1'b1;
        #2 reset = 1'b0;
        #1;
        checks++;
        if (q !== 16'h0000) begin errors++; $display("FAIL mid_q: got %h want 0000", q); end
        checks++;
        if (segment !== 4'b1110) begin
            errors++; $display("FAIL mid_seg: got %b want 1110", segment);
        end
        checks++;
        if (led !== 7'b0000001) begin
            errors++; $display("FAIL mid_led: got %b want 0000001", led);
        end
        checks++;
        if (upd !== 1'b0) begin errors++; $display("FAIL mid_upd: got %b want 0", upd); end
        repeat (2) @(posedge clk);
        #2 reset = 1'b1;
        q_bad = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (q !== 16'h0000 || upd !== 1'b0) q_bad++;
        end
        checks++;
        if (q_bad != 0) begin
            errors++; $display("FAIL mid_held_valid: got %0d accepting cycles want 0", q_bad);
        end
        valid_in = 1'b0;
        tick();
        valid_in = 1'b1;
        tick();
        checks++;
        if (q !== 16'h0010) begin errors++; $display("FAIL mid_rearm_q: got %h want 0010", q); end
        checks++;
        if (upd !== 1'b1) begin errors++; $display("FAIL mid_rearm_upd: got %b want 1", upd); end
        valid_in = 1'b0;
        tick();
    endtask

    initial begin
        test_reset();
        test_write();
        test_toggle_hold();
        test_patterns();
        test_scan();
        test_lz();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
